// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI slave port
package spi_pkg;
    typedef enum logic {IDLE, SHIFT} state_e;
    localparam int BYTE_BITS = 8;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one async pin with rise/fall detect
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES:0] sh_q, sh_d;
    always_comb sh_d = {sh_q[SYNC_STAGES-1:0], pin};
    always_ff @(posedge Clk) begin
        if (Reset) sh_q <= {(SYNC_STAGES+1){RST_VAL}};
        else       sh_q <= sh_d;
    end
    // top bit is the previous synchronized sample, kept only for edge detect
    assign sync = sh_q[SYNC_STAGES-1];
    assign rise = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
    assign fall = ~sh_q[SYNC_STAGES-1] & sh_q[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI mode-0 slave with TX holding register and RX strobe; SPI_SLAVE_FRAME_CNT_EN adds a per-frame byte counter
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
`ifdef SPI_SLAVE_FRAME_CNT_EN
    ,
    output logic [7:0] frame_bytes,
    output logic       frame_done
`endif
);
    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic ss_unused_sync, sclk_unused_sync, mosi_unused_rise, mosi_unused_fall;
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .Clk(Clk), .Reset(Reset), .pin(spi_sclk), .sync(sclk_unused_sync), .rise(sclk_rise), .fall(sclk_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .Clk(Clk), .Reset(Reset), .pin(spi_ss_n), .sync(ss_unused_sync), .rise(ss_rise), .fall(ss_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .Clk(Clk), .Reset(Reset), .pin(spi_mosi), .sync(mosi_s), .rise(mosi_unused_rise), .fall(mosi_unused_fall));

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, hold_q, hold_d, rx_data_q, rx_data_d;
    logic       hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic       miso_q, miso_d, oe_q, oe_d, busy_q, busy_d, load, byte_done;

    assign byte_done = state_q == SHIFT && !ss_rise && bit_cnt_q == 4'(BYTE_BITS);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;
        if (state_q == IDLE) begin
            if (ss_fall) begin
                load      = 1'b1;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
        end else if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end
            if (byte_done) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
            end
            // a fall at count 0 is the trailing edge of a finished byte: fetch the next one
            if (sclk_fall) begin
                load       = bit_cnt_q == '0;
                tx_shift_d = (bit_cnt_q != '0 && bit_cnt_q < 4'(BYTE_BITS)) ? tx_shift_q << 1 : tx_shift_q;
            end
        end
        if (load) begin
            tx_shift_d  = hold_full_q ? hold_q : IDLE_BYTE;
            underrun_d  = !hold_full_q;
            hold_full_d = 1'b0;
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        oe_d   = state_q == SHIFT;
        miso_d = state_q == SHIFT ? tx_shift_q[7] : 1'b1;
        busy_d = state_d == SHIFT;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= IDLE_BYTE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = !hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = busy_q;

`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [7:0] fb_q, fb_d;
    logic       fd_q, fd_d;
    always_comb begin
        fb_d = (state_q == IDLE && ss_fall) ? 8'd0 : fb_q;
        fb_d = (byte_done && fb_q != 8'hFF) ? fb_q + 8'd1 : fb_d;
        fd_d = state_q == SHIFT && ss_rise;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_q <= '0;
            fd_q <= 1'b0;
        end else begin
            fb_q <= fb_d;
            fd_q <= fd_d;
        end
    end
    assign frame_bytes = fb_q;
    assign frame_done  = fd_q;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed mode-0 master with RX scoreboard and pulse monitors
module tb_spi_slave_port;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       Clk = 1'b0, Reset = 1'b1;
    logic       spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       tx_valid = 1'b0;
`ifdef SPI_SLAVE_FRAME_CNT_EN
    logic [7:0] frame_bytes;
    logic       frame_done;
`endif

    spi_slave_port #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .Clk(Clk), .Reset(Reset), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
`ifdef SPI_SLAVE_FRAME_CNT_EN
        , .frame_bytes(frame_bytes), .frame_done(frame_done)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_rise = 0, rx_cnt = 0, un_cnt = 0, oe_hi = 0, fd_cnt = 0, last_fb = 0;
    logic [7:0] exp_rx[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (spi_miso_oe) oe_hi <= oe_hi + 1;
        if (tx_underrun) un_cnt <= un_cnt + 1;
        if (rx_valid) begin
            rx_cnt <= rx_cnt + 1;
            if (exp_rx.size() == 0) chk("rx_unexpected", int'(rx_data), -1);
            else begin
                chk("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
                chk("rx_latency", cyc - last_rise, SYNC + 2);
            end
        end
`ifdef SPI_SLAVE_FRAME_CNT_EN
        if (frame_done) begin
            fd_cnt  <= fd_cnt + 1;
            last_fb <= int'(frame_bytes);
        end
`endif
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge Clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] m, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = m[i];
            wait_clk(HALF);
            spi_sclk  = 1'b1;
            last_rise = cyc;
            r[i]      = spi_miso;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] m, input logic [7:0] exp_miso);
        logic [7:0] r;
        exp_rx.push_back(m);
        spi_bits(m, 8, r);
        chk(tag, int'(r), int'(exp_miso));
    endtask

    task automatic frame_begin();
        spi_ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(HALF);
    endtask

    initial begin
        int u0, r0, o0, f0;
        logic [7:0] junk;
        wait_clk(3);
        chk("rst_miso", spi_miso, 1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_busy", busy, 0);
        Reset = 1'b0;
        wait_clk(4);

        // single byte: A5 out, 3C in
        tx_write(8'hA5);
        chk("t1_hold_full", tx_ready, 0);
        u0 = un_cnt;
        frame_begin();
        chk("t1_busy", busy, 1);
        chk("t1_oe", spi_miso_oe, 1);
        chk("t1_tx_ready_back", tx_ready, 1);
        xfer("t1_miso", 8'h3C, 8'hA5);
        chk("t1_no_underrun", un_cnt - u0, 0);
        frame_end();
        chk("t1_oe_off", spi_miso_oe, 0);

        // back-to-back bytes with writes during the frame
        tx_write(8'h10);
        u0 = un_cnt;
        frame_begin();
        tx_write(8'h20);
        xfer("t2_miso0", 8'h01, 8'h10);
        xfer("t2_miso1", 8'h02, 8'h20);
        xfer("t2_miso2", 8'h03, 8'hFF);
        chk("t2_underrun", un_cnt - u0, 1);
        frame_end();
        chk("t2_rx_drained", exp_rx.size(), 0);

        // abort after 5 rises of F0
        r0 = rx_cnt;
        frame_begin();
        spi_bits(8'hF0, 5, junk);
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(SYNC + 2);
        chk("t3_oe_off", spi_miso_oe, 0);
        chk("t3_busy_off", busy, 0);
        wait_clk(HALF);
        chk("t3_no_rx", rx_cnt - r0, 0);
        frame_begin();
        xfer("t3_realign_miso", 8'h96, 8'hFF);
        frame_end();

        // SCLK activity while deselected
        tx_write(8'h5A);
        r0 = rx_cnt;
        o0 = oe_hi;
        for (int i = 0; i < 16; i++) begin
            spi_sclk = ~spi_sclk;
            wait_clk(HALF);
        end
        chk("t4_no_rx", rx_cnt - r0, 0);
        chk("t4_oe_low", oe_hi - o0, 0);
        chk("t4_hold_kept", tx_ready, 0);
        frame_begin();
        xfer("t4_miso", 8'hC7, 8'h5A);
        frame_end();

        // reset mid-byte with holding register full
        frame_begin();
        tx_write(8'hC3);
        chk("t5_hold_full", tx_ready, 0);
        spi_bits(8'hAA, 3, junk);
        Reset    = 1'b1;
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(1);
        chk("t5_miso", spi_miso, 1);
        chk("t5_oe", spi_miso_oe, 0);
        chk("t5_tx_ready", tx_ready, 1);
        chk("t5_rx_data", int'(rx_data), 0);
        chk("t5_rx_valid", rx_valid, 0);
        chk("t5_busy", busy, 0);
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(4);
        frame_begin();
        xfer("t5_idle_byte", 8'h77, 8'hFF);
        frame_end();

`ifdef SPI_SLAVE_FRAME_CNT_EN
        f0 = fd_cnt;
        frame_begin();
        for (int i = 0; i < 4; i++) xfer("t6_miso", 8'(i + 8'h40), 8'hFF);
        frame_end();
        wait_clk(4);
        chk("t6_frame_done", fd_cnt - f0, 1);
        chk("t6_frame_bytes", last_fb, 4);
        chk("t6_frame_hold", int'(frame_bytes), 4);
        f0 = fd_cnt;
        frame_begin();
        for (int i = 0; i < 300; i++) xfer("t7_miso", 8'(i), 8'hFF);
        frame_end();
        wait_clk(4);
        chk("t7_frame_done", fd_cnt - f0, 1);
        chk("t7_saturate", last_fb, 255);
`else
        f0 = 0;
`endif
        wait_clk(8);
        chk("rx_queue_empty", exp_rx.size(), f0 * 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
